regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader_if.sv | 32 +++
 rtl/regfile_reader.sv | 119 +++++++++++
 tb/tb_regfile_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_reader_if.sv
// Handshake bundle for regfile_reader: dump request, register-file read ports
// and the output word stream with status pulses.
interface regfile_reader_if #(
    parameter int DW = 32
);
    logic          start;
    logic [4:0]    first_reg;
    logic [4:0]    last_reg;
    logic          abort;
    logic [4:0]    Rn1;
    logic [4:0]    Rn2;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [4:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, first_reg, last_reg, abort, A, B, out_ready,
        output Rn1, Rn2, out_valid, out_data, out_idx, out_last, busy, done, err
    );

    modport master (
        output start, first_reg, last_reg, abort, A, B, out_ready,
        input  Rn1, Rn2, out_valid, out_data, out_idx, out_last, busy, done, err
    );
endinterface

// File: rtl/regfile_reader.sv
// Streams register-file contents first_reg..last_reg, two reads per capture,
// through a 2-entry output FIFO with valid/ready handshake.
module regfile_reader #(
    parameter int DW = 32
) (
    input logic           Clock,
    input logic           Resetn,
    regfile_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t        state;
    logic [4:0]    ptr;
    logic [4:0]    end_q;
    logic [1:0]    count;
    logic [DW-1:0] data_q [2];
    logic [4:0]    idx_q  [2];
    logic          last_q [2];
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic       pop;
    logic       pair;
    logic       capture;
    logic       hits_end;
    logic [4:0] ptr_inc;

    // A capture only happens once the FIFO is effectively empty, so both
    // entries are always written from scratch and ptr+1 is never used past end.
    always_comb begin
        pop      = (count != 2'd0) && bus.out_ready;
        pair     = ptr < end_q;
        ptr_inc  = ptr + 5'd1;
        capture  = (state == FETCH) && ((count == 2'd0) || ((count == 2'd1) && pop));
        hits_end = !pair || (ptr_inc == end_q);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            end_q     <= '0;
            count     <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            idx_q[0]  <= '0;
            idx_q[1]  <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.first_reg <= bus.last_reg) begin
                            ptr    <= bus.first_reg;
                            end_q  <= bus.last_reg;
                            state  <= FETCH;
                            busy_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end else if (capture) begin
                        data_q[0] <= bus.A;
                        idx_q[0]  <= ptr;
                        last_q[0] <= (ptr == end_q);
                        data_q[1] <= bus.B;
                        idx_q[1]  <= ptr_inc;
                        last_q[1] <= (ptr_inc == end_q);
                        count     <= pair ? 2'd2 : 2'd1;
                        ptr       <= pair ? (ptr + 5'd2) : ptr_inc;
                        if (hits_end) begin
                            state <= DRAIN;
                        end
                    end else if (pop) begin
                        data_q[0] <= data_q[1];
                        idx_q[0]  <= idx_q[1];
                        last_q[0] <= last_q[1];
                        count     <= count - 2'd1;
                        if ((state == DRAIN) && last_q[0]) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Rn1       = (state == FETCH) ? ptr : '0;
    assign bus.Rn2       = (state == FETCH) ? (pair ? ptr_inc : ptr) : '0;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = data_q[0];
    assign bus.out_idx   = idx_q[0];
    assign bus.out_last  = last_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader against a small registered-write register file.
module tb_regfile_reader;
    logic Clock = 1'b0;
    logic Resetn;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rf [32] = '{default: '0};

    regfile_reader_if #(.DW(32)) bus ();

    regfile_reader #(.DW(32)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (we) rf[waddr] <= wdata;
    end

    assign bus.A = rf[bus.Rn1];
    assign bus.B = rf[bus.Rn2];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [4:0] idx, input logic [31:0] data,
                            input logic last);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
        chk({tag, ".data"},  bus.out_data,       data);
        chk({tag, ".last"},  32'(bus.out_last),  32'(last));
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic begin_dump(input logic [4:0] f, input logic [4:0] l);
        bus.start = 1'b1; bus.first_reg = f; bus.last_reg = l;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        bus.start = 1'b0; bus.first_reg = '0; bus.last_reg = '0;
        bus.abort = 1'b0; bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.busy",  32'(bus.busy),      32'd0);
        chk("rst.done",  32'(bus.done),      32'd0);
        chk("rst.err",   32'(bus.err),       32'd0);
        chk("rst.Rn1",   32'(bus.Rn1),       32'd0);
        chk("rst.Rn2",   32'(bus.Rn2),       32'd0);
        chk("rst.data",  bus.out_data,       32'd0);
        chk("rst.idx",   32'(bus.out_idx),   32'd0);
        chk("rst.last",  32'(bus.out_last),  32'd0);
        Resetn = 1'b1;

        write_reg(5'd1, 32'd1023);
        write_reg(5'd3, 32'd2047);
        write_reg(5'd5, 32'd55);
        write_reg(5'd30, 32'd300);
        write_reg(5'd31, 32'd311);

        // Range 1..3, consumer always ready
        begin_dump(5'd1, 5'd3);
        chk("r13.busy",  32'(bus.busy),      32'd1);
        chk("r13.lat",   32'(bus.out_valid), 32'd0);
        chk("r13.Rn1",   32'(bus.Rn1),       32'd1);
        chk("r13.Rn2",   32'(bus.Rn2),       32'd2);
        tick(); chk_word("r13.w1", 5'd1, 32'd1023, 1'b0);
        tick(); chk_word("r13.w2", 5'd2, 32'd0,    1'b0);
        tick(); chk_word("r13.w3", 5'd3, 32'd2047, 1'b1);
        tick();
        chk("r13.done",   32'(bus.done),      32'd1);
        chk("r13.dvalid", 32'(bus.out_valid), 32'd0);
        chk("r13.dRn1",   32'(bus.Rn1),       32'd0);
        tick();
        chk("r13.done0", 32'(bus.done), 32'd0);
        chk("r13.idle",  32'(bus.busy), 32'd0);

        // Single register
        begin_dump(5'd5, 5'd5);
        chk("r55.Rn1", 32'(bus.Rn1), 32'd5);
        chk("r55.Rn2", 32'(bus.Rn2), 32'd5);
        tick(); chk_word("r55.w", 5'd5, 32'd55, 1'b1);
        tick(); chk("r55.done", 32'(bus.done), 32'd1);
        tick(); chk("r55.idle", 32'(bus.busy), 32'd0);

        // Top of the file with back-pressure; a start while busy is ignored
        bus.out_ready = 1'b0;
        begin_dump(5'd30, 5'd31);
        chk("r31.Rn1", 32'(bus.Rn1), 32'd30);
        chk("r31.Rn2", 32'(bus.Rn2), 32'd31);
        tick(); chk_word("r31.hold0", 5'd30, 32'd300, 1'b0);
        begin_dump(5'd0, 5'd0);
        chk_word("r31.hold1", 5'd30, 32'd300, 1'b0);
        chk("r31.noerr", 32'(bus.err), 32'd0);
        tick(); chk_word("r31.hold2", 5'd30, 32'd300, 1'b0);
        bus.out_ready = 1'b1;
        tick(); chk_word("r31.w31", 5'd31, 32'd311, 1'b1);
        tick(); chk("r31.done", 32'(bus.done), 32'd1);
        tick(); chk("r31.idle", 32'(bus.busy), 32'd0);

        // Reversed range
        begin_dump(5'd4, 5'd2);
        chk("rev.err",   32'(bus.err),       32'd1);
        chk("rev.busy",  32'(bus.busy),      32'd0);
        chk("rev.valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("rev.err0",  32'(bus.err),       32'd0);
        chk("rev.valid1", 32'(bus.out_valid), 32'd0);

        // Full range, aborted after five accepted words
        begin_dump(5'd0, 5'd31);
        tick(); chk_word("abt.w0", 5'd0, 32'd0,    1'b0);
        tick(); chk_word("abt.w1", 5'd1, 32'd1023, 1'b0);
        tick(); chk_word("abt.w2", 5'd2, 32'd0,    1'b0);
        tick(); chk_word("abt.w3", 5'd3, 32'd2047, 1'b0);
        tick(); chk_word("abt.w4", 5'd4, 32'd0,    1'b0);
        tick(); chk_word("abt.w5", 5'd5, 32'd55,   1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abt.valid", 32'(bus.out_valid), 32'd0);
        chk("abt.busy",  32'(bus.busy),      32'd0);
        chk("abt.done",  32'(bus.done),      32'd0);
        tick();
        chk("abt.done1", 32'(bus.done), 32'd0);

        // Write to R1 on the capture edge: old value is streamed
        begin_dump(5'd1, 5'd1);
        we = 1'b1; waddr = 5'd1; wdata = 32'd77;
        tick();
        we = 1'b0;
        chk_word("wr.old", 5'd1, 32'd1023, 1'b1);
        tick(); chk("wr.done", 32'(bus.done), 32'd1);
        tick();

        // Reset mid-dump
        begin_dump(5'd0, 5'd31);
        tick(); chk("mid.valid", 32'(bus.out_valid), 32'd1);
        Resetn = 1'b0;
        tick();
        chk("mid.rvalid", 32'(bus.out_valid), 32'd0);
        chk("mid.rbusy",  32'(bus.busy),      32'd0);
        chk("mid.rdata",  bus.out_data,       32'd0);
        Resetn = 1'b1;
        tick();
        chk("mid.done",   32'(bus.done),      32'd0);
        chk("mid.valid2", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
